// File: rtl/wr_pps_monitor.sv
// PPS / clk_sys health monitor: period measurement, lock qualification, miss/bad counting, per-second event bins.
// Optional per-channel event timestamps are enabled by defining WR_PPS_MON_TSTAMP_EN.
module wr_pps_monitor #(
  parameter int CLK_FREQ = 125000000,
  parameter int TOL      = 1000,
  parameter int LOCK_CNT = 4,
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 32
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_n_i,
  input  logic                    pps_i,
  input  logic                    clear_i,
  input  logic [NUM_CH-1:0]       ev_i,
  output logic [CNT_W-1:0]        pps_cnt_o,
  output logic [CNT_W-1:0]        period_o,
  output logic [CNT_W-1:0]        miss_cnt_o,
  output logic [CNT_W-1:0]        bad_cnt_o,
  output logic                    locked_o,
  output logic [1:0]              state_o,
  output logic [NUM_CH*CNT_W-1:0] ev_cnt_o,
`ifdef WR_PPS_MON_TSTAMP_EN
  output logic [NUM_CH*CNT_W-1:0] ev_ts_o,
`endif
  output logic                    ev_valid_o
);

  typedef enum logic [1:0] {ACQUIRE = 2'd0, QUALIFY = 2'd1, LOCKED = 2'd2, FAULT = 2'd3} state_t;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] PER_LO = CNT_W'(CLK_FREQ - TOL);
  localparam logic [CNT_W-1:0] PER_HI = CNT_W'(CLK_FREQ + TOL);
  localparam logic [7:0]       LOCK_N = 8'(LOCK_CNT);

  state_t                        state_q, state_d;
  logic [7:0]                    good_run_q, good_run_d;
  logic                          pps_d_q;
  logic [CNT_W-1:0]              cyc_q, cyc_d;
  logic [CNT_W-1:0]              pps_cnt_q, pps_cnt_d;
  logic [CNT_W-1:0]              period_q, period_d;
  logic [CNT_W-1:0]              miss_q, miss_d;
  logic [CNT_W-1:0]              bad_q, bad_d;
  logic                          ev_valid_q;
  logic [NUM_CH-1:0]             sync1_q, sync2_q, sync3_q;
  logic [NUM_CH-1:0][CNT_W-1:0]  live_q, live_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  ev_cnt_q, ev_cnt_d;
`ifdef WR_PPS_MON_TSTAMP_EN
  logic [NUM_CH-1:0][CNT_W-1:0]  ts_live_q, ts_live_d;
  logic [NUM_CH-1:0][CNT_W-1:0]  ev_ts_q, ev_ts_d;
`endif

  logic              pps_re, good_period, timeout, miss_inc, bad_inc;
  logic [CNT_W-1:0]  cyc_inc;
  logic [NUM_CH-1:0] ev_re;

  assign pps_re      = pps_i & ~pps_d_q;
  assign cyc_inc     = (&cyc_q) ? cyc_q : cyc_q + ONE;
  assign good_period = (cyc_inc >= PER_LO) && (cyc_inc <= PER_HI);
  assign timeout     = (cyc_q == PER_HI) && !pps_re;
  assign ev_re       = sync2_q & ~sync3_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    miss_inc   = 1'b0;
    bad_inc    = 1'b0;
    case (state_q)
      ACQUIRE: if (pps_re) state_d = QUALIFY;
      QUALIFY: begin
        if (pps_re && good_period) begin
          good_run_d = good_run_q + 8'd1;
          if (good_run_d == LOCK_N) state_d = LOCKED;
        end else if (pps_re || timeout) begin
          bad_inc    = pps_re;
          miss_inc   = timeout;
          good_run_d = 8'd0;
          state_d    = FAULT;
        end
      end
      LOCKED: begin
        if ((pps_re && !good_period) || timeout) begin
          bad_inc    = pps_re;
          miss_inc   = timeout;
          good_run_d = 8'd0;
          state_d    = FAULT;
        end
      end
      FAULT: begin
        if (pps_re && good_period) begin
          good_run_d = 8'd1;
          state_d    = (LOCK_N == 8'd1) ? LOCKED : QUALIFY;
        end else begin
          bad_inc  = pps_re;
          miss_inc = timeout;
        end
      end
      default: state_d = ACQUIRE;
    endcase
  end

  // A clear on the same cycle as an increment wins.
  always_comb begin
    cyc_d     = pps_re ? '0 : cyc_inc;
    pps_cnt_d = pps_re ? pps_cnt_q + ONE : pps_cnt_q;
    period_d  = pps_re ? cyc_inc : period_q;
    miss_d    = (miss_inc && !(&miss_q)) ? miss_q + ONE : miss_q;
    bad_d     = (bad_inc && !(&bad_q)) ? bad_q + ONE : bad_q;
    if (clear_i) begin
      miss_d = '0;
      bad_d  = '0;
    end
  end

  // An event edge coincident with pps_re opens the new second's bin.
  always_comb begin
    live_d   = live_q;
    ev_cnt_d = ev_cnt_q;
`ifdef WR_PPS_MON_TSTAMP_EN
    ts_live_d = ts_live_q;
    ev_ts_d   = ev_ts_q;
`endif
    for (int k = 0; k < NUM_CH; k++) begin
      if (pps_re) begin
        ev_cnt_d[k] = live_q[k];
        live_d[k]   = {{(CNT_W-1){1'b0}}, ev_re[k]};
`ifdef WR_PPS_MON_TSTAMP_EN
        ev_ts_d[k]   = ts_live_q[k];
        ts_live_d[k] = '0;
`endif
      end else if (ev_re[k]) begin
        if (!(&live_q[k])) live_d[k] = live_q[k] + ONE;
`ifdef WR_PPS_MON_TSTAMP_EN
        ts_live_d[k] = cyc_inc;
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ACQUIRE;
      good_run_q <= '0;
      pps_d_q    <= 1'b0;
      cyc_q      <= '0;
      pps_cnt_q  <= '0;
      period_q   <= '0;
      miss_q     <= '0;
      bad_q      <= '0;
      ev_valid_q <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync3_q    <= '0;
      live_q     <= '0;
      ev_cnt_q   <= '0;
`ifdef WR_PPS_MON_TSTAMP_EN
      ts_live_q  <= '0;
      ev_ts_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      good_run_q <= good_run_d;
      pps_d_q    <= pps_i;
      cyc_q      <= cyc_d;
      pps_cnt_q  <= pps_cnt_d;
      period_q   <= period_d;
      miss_q     <= miss_d;
      bad_q      <= bad_d;
      ev_valid_q <= pps_re;
      sync1_q    <= ev_i;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      live_q     <= live_d;
      ev_cnt_q   <= ev_cnt_d;
`ifdef WR_PPS_MON_TSTAMP_EN
      ts_live_q  <= ts_live_d;
      ev_ts_q    <= ev_ts_d;
`endif
    end
  end

  assign pps_cnt_o  = pps_cnt_q;
  assign period_o   = period_q;
  assign miss_cnt_o = miss_q;
  assign bad_cnt_o  = bad_q;
  assign locked_o   = (state_q == LOCKED);
  assign state_o    = state_q;
  assign ev_cnt_o   = ev_cnt_q;
  assign ev_valid_o = ev_valid_q;
`ifdef WR_PPS_MON_TSTAMP_EN
  assign ev_ts_o    = ev_ts_q;
`endif

endmodule
